// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter in front of
// the PWM register interface.
package wb_arb_pkg;

    localparam int unsigned ADR_W = 16;
    localparam int unsigned DAT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // Register offsets of the PWM register interface behind the arbiter
    localparam logic [ADR_W-1:0] CTRL   = 16'h0000;
    localparam logic [ADR_W-1:0] DIV    = 16'h0002;
    localparam logic [ADR_W-1:0] PERIOD = 16'h0004;
    localparam logic [ADR_W-1:0] DC     = 16'h0006;

    typedef struct packed {
        logic             we;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// One Wishbone link (request + ack); used for each master port and the slave port.
interface wb_arbiter_if;
    import wb_arb_pkg::*;

    logic             cyc;
    logic             stb;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] data;
    logic             ack;

    modport master (output cyc, stb, we, adr, data, input ack);
    modport slave  (input cyc, stb, we, adr, data, output ack);

endinterface

// File: rtl/wb_arb_timeout.sv
// Stall counter for the granted strobe; expire_c flags the clock on which the
// bus is forced free because the slave never acked.
module wb_arb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TO_W           = 5
) (
    input  logic i_wb_clk,
    input  logic i_wb_rst,
    input  logic restart,
    input  logic stb,
    input  logic ack,
    output logic expire_c
);

    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            to_cnt <= '0;
        end else if (restart || !stb || ack) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign expire_c = stb && !ack && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin two-master Wishbone arbiter for the PWM register slave.
// Define WB_ARB_TIMEOUT_EN to add the stalled-slave timeout and per-master err.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TO_W           = 5
) (
    input  logic         i_wb_clk,
    input  logic         i_wb_rst,
    wb_arbiter_if.slave  m0,
    wb_arbiter_if.slave  m1,
    wb_arbiter_if.master s,
    output logic         o_m0_err,
    output logic         o_m1_err,
    output logic [1:0]   o_gnt
);

    if (TIMEOUT_CYCLES >= (32'd1 << TO_W)) begin : g_bad_to_w
        $error("wb_arbiter: TO_W too narrow for TIMEOUT_CYCLES");
    end

    arb_state_e state_q, state_d;
    logic       rr_last_q, rr_last_d;
    logic       req0, req1;
    logic       to_expire;
    logic       sel_cyc, sel_stb;
    wb_req_t    sel;

`ifdef WB_ARB_TIMEOUT_EN
    logic [1:0] blk_q;
    logic       grant_change;

    assign grant_change = (state_d != state_q);

    wb_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timeout (
        .i_wb_clk (i_wb_clk),
        .i_wb_rst (i_wb_rst),
        .restart  (grant_change),
        .stb      (sel_stb),
        .ack      (s.ack),
        .expire_c (to_expire)
    );

    // A timed-out master stays blocked while it holds CYC until the other one is granted
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            blk_q    <= 2'b00;
            o_m0_err <= 1'b0;
            o_m1_err <= 1'b0;
        end else begin
            blk_q[0] <= (blk_q[0] | (to_expire & o_gnt[0])) & m0.cyc & (state_q != ST_GNT1);
            blk_q[1] <= (blk_q[1] | (to_expire & o_gnt[1])) & m1.cyc & (state_q != ST_GNT0);
            o_m0_err <= to_expire & o_gnt[0];
            o_m1_err <= to_expire & o_gnt[1];
        end
    end

    assign req0 = m0.cyc & ~blk_q[0];
    assign req1 = m1.cyc & ~blk_q[1];
`else
    assign to_expire = 1'b0;
    assign req0      = m0.cyc;
    assign req1      = m1.cyc;
    assign o_m0_err  = 1'b0;
    assign o_m1_err  = 1'b0;
`endif

    // State register; rr_last resets to 1 so m0 wins the first tie
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_q   <= ST_IDLE;
            rr_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
        end
    end

    // Next state: grant held for the whole CYC, handover without an idle gap
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req0 && req1) begin
                    state_d = rr_last_q ? ST_GNT0 : ST_GNT1;
                end else if (req0) begin
                    state_d = ST_GNT0;
                end else if (req1) begin
                    state_d = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!m0.cyc || to_expire) begin
                    rr_last_d = 1'b0;
                    state_d   = m1.cyc ? ST_GNT1 : ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (!m1.cyc || to_expire) begin
                    rr_last_d = 1'b1;
                    state_d   = m0.cyc ? ST_GNT0 : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: grant decode and granted-master request select
    always_comb begin
        o_gnt   = GNT_NONE;
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        sel     = '0;
        unique case (state_q)
            ST_GNT0: begin
                o_gnt    = GNT_M0;
                sel_cyc  = m0.cyc;
                sel_stb  = m0.stb;
                sel.we   = m0.we;
                sel.adr  = m0.adr;
                sel.data = m0.data;
            end
            ST_GNT1: begin
                o_gnt    = GNT_M1;
                sel_cyc  = m1.cyc;
                sel_stb  = m1.stb;
                sel.we   = m1.we;
                sel.adr  = m1.adr;
                sel.data = m1.data;
            end
            default: ;
        endcase
    end

    assign s.cyc  = sel_cyc;
    assign s.stb  = sel_stb & ~to_expire;
    assign s.we   = sel.we;
    assign s.adr  = sel.adr;
    assign s.data = sel.data;

    assign m0.ack = s.ack & o_gnt[0];
    assign m1.ack = s.ack & o_gnt[1];

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized masters/slave,
// compared each cycle against an ownership-level reference model.
module tb_wb_arbiter;
    import wb_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if m0_if ();
    wb_arbiter_if m1_if ();
    wb_arbiter_if s_if ();

    logic             m0_err, m1_err;
    logic [1:0]       o_gnt;
    logic             m_cyc  [2];
    logic             m_stb  [2];
    logic             m_we   [2];
    logic [ADR_W-1:0] m_adr  [2];
    logic [DAT_W-1:0] m_data [2];
    logic             s_ack;

    assign m0_if.cyc  = m_cyc[0];
    assign m0_if.stb  = m_stb[0];
    assign m0_if.we   = m_we[0];
    assign m0_if.adr  = m_adr[0];
    assign m0_if.data = m_data[0];
    assign m1_if.cyc  = m_cyc[1];
    assign m1_if.stb  = m_stb[1];
    assign m1_if.we   = m_we[1];
    assign m1_if.adr  = m_adr[1];
    assign m1_if.data = m_data[1];
    assign s_if.ack   = s_ack;

    wb_arbiter dut (
        .i_wb_clk (clk),
        .i_wb_rst (rst),
        .m0       (m0_if),
        .m1       (m1_if),
        .s        (s_if),
        .o_m0_err (m0_err),
        .o_m1_err (m1_err),
        .o_gnt    (o_gnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: who owns the bus and who was served last
    int owner = -1;
    int last  = 1;
    int stall = 0;

    // Random master agents
    bit               busy     [2];
    int               beats    [2];
    int               idle     [2];
    bit               ack_seen [2];
    bit               persist  = 1'b0;
    logic [ADR_W-1:0] reg_adr  [4];
    logic [1:0]       seq_q    [$];
    logic [1:0]       last_g;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic void model_edge();
        if (rst) begin
            owner = -1;
            last  = 1;
        end else if (owner < 0) begin
            if (m_cyc[0] && m_cyc[1]) owner = 1 - last;
            else if (m_cyc[0])        owner = 0;
            else if (m_cyc[1])        owner = 1;
        end else if (!m_cyc[owner]) begin
            last  = owner;
            owner = m_cyc[1 - owner] ? 1 - owner : -1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic sample();
        logic [1:0]       eg;
        logic             ec, es, ew;
        logic [ADR_W-1:0] ea;
        logic [DAT_W-1:0] ed;
        @(negedge clk);
        eg = GNT_NONE; ec = 1'b0; es = 1'b0; ew = 1'b0; ea = '0; ed = '0;
        if (owner >= 0) begin
            eg = (owner == 0) ? GNT_M0 : GNT_M1;
            ec = m_cyc[owner]; es = m_stb[owner]; ew = m_we[owner];
            ea = m_adr[owner]; ed = m_data[owner];
        end
        check("gnt",    32'(o_gnt),      32'(eg));
        check("s_cyc",  32'(s_if.cyc),   32'(ec));
        check("s_stb",  32'(s_if.stb),   32'(es));
        check("s_we",   32'(s_if.we),    32'(ew));
        check("s_adr",  32'(s_if.adr),   32'(ea));
        check("s_data", 32'(s_if.data),  32'(ed));
        check("m0_ack", 32'(m0_if.ack),  32'(s_ack && owner == 0));
        check("m1_ack", 32'(m1_if.ack),  32'(s_ack && owner == 1));
        check("err",    32'({m1_err, m0_err}), 32'd0);
        for (int i = 0; i < 2; i++) ack_seen[i] = s_ack && (owner == i) && m_stb[i];
        if (owner >= 0 && m_stb[owner] && !s_ack) stall++;
        else stall = 0;
    endtask

    task automatic new_beat(input int i);
        m_stb[i]  = 1'b1;
        m_we[i]   = 1'($urandom);
        m_adr[i]  = reg_adr[$urandom_range(0, 3)];
        if ($urandom_range(0, 3) == 0) m_adr[i] = 16'($urandom);
        m_data[i] = 16'($urandom);
    endtask

    task automatic drive_random();
        for (int i = 0; i < 2; i++) begin
            if (busy[i]) begin
                if (ack_seen[i]) begin
                    beats[i]--;
                    if (beats[i] == 0) begin
                        busy[i]  = 1'b0;
                        m_cyc[i] = 1'b0;
                        m_stb[i] = 1'b0;
                        idle[i]  = persist ? 0 : int'($urandom_range(0, 3));
                    end else begin
                        new_beat(i);
                    end
                end
            end else if (idle[i] > 0) begin
                idle[i]--;
            end else if (persist || $urandom_range(0, 1) == 1) begin
                busy[i]  = 1'b1;
                beats[i] = persist ? 1 : int'($urandom_range(1, 4));
                m_cyc[i] = 1'b1;
                new_beat(i);
            end
        end
        s_ack = persist || (stall >= 8) || ($urandom_range(0, 99) < 40);
    endtask

    task automatic clear_masters();
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
            m_adr[i] = '0; m_data[i] = '0;
            busy[i] = 1'b0; idle[i] = 0; beats[i] = 0; ack_seen[i] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reg_adr = '{CTRL, DIV, PERIOD, DC};
        rst   = 1'b1;
        s_ack = 1'b0;
        clear_masters();

        // Reset state
        tick();
        sample();
        check("rst_gnt", 32'(o_gnt), 32'd0);
        check("rst_s_cyc", 32'(s_if.cyc), 32'd0);

        // m0 write to PERIOD: one clock grant latency, ack routed only to m0
        tick();
        rst = 1'b0;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
        m_adr[0] = 16'h0004; m_data[0] = 16'h00FF;
        sample();
        check("lat_gnt", 32'(o_gnt), 32'd0);
        tick();
        s_ack = 1'b1;
        sample();
        check("w_gnt",  32'(o_gnt),     32'h1);
        check("w_adr",  32'(s_if.adr),  32'h0004);
        check("w_data", 32'(s_if.data), 32'h00FF);
        check("w_we",   32'(s_if.we),   32'h1);
        check("w_ack0", 32'(m0_if.ack), 32'h1);
        check("w_ack1", 32'(m1_if.ack), 32'h0);
        tick();
        clear_masters();
        sample();
        tick();
        s_ack = 1'b1;
        sample();
        check("idle_ack", 32'({m1_if.ack, m0_if.ack}), 32'd0);

        // m1 holds four back-to-back beats while m0 waits
        tick();
        s_ack = 1'b0;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = DC; m_data[1] = 16'h1234;
        sample();
        tick();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = CTRL;
        sample();
        check("m1_gnt", 32'(o_gnt), 32'h2);
        for (int b = 0; b < 4; b++) begin
            tick();
            s_ack = 1'b1;
            m_data[1] = 16'($urandom);
            sample();
            check("burst_gnt", 32'(o_gnt), 32'h2);
            check("burst_ack0", 32'(m0_if.ack), 32'h0);
        end

        // Asynchronous reset mid-transfer under GNT1
        tick();
        s_ack = 1'b0;
        sample();
        #2;
        rst = 1'b1;
        #1;
        check("arst_gnt",   32'(o_gnt),    32'd0);
        check("arst_s_cyc", 32'(s_if.cyc), 32'd0);
        owner = -1;
        last  = 1;
        tick();
        rst = 1'b0;
        sample();
        tick();
        sample();
        check("tie_gnt", 32'(o_gnt), 32'h1);
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        sample();
        tick();
        sample();
        check("handover_gnt", 32'(o_gnt), 32'h2);
        tick();
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        sample();
        tick();
        sample();

        // Both masters requesting continuously: grants alternate
        clear_masters();
        persist = 1'b1;
        last_g  = GNT_NONE;
        for (int c = 0; c < 24; c++) begin
            tick();
            drive_random();
            sample();
            if (o_gnt != GNT_NONE && o_gnt != last_g) begin
                seq_q.push_back(o_gnt);
                last_g = o_gnt;
            end
        end
        for (int k = 0; k < 6; k++) begin
            logic [1:0] want;
            want = (k % 2 == 0) ? GNT_M0 : GNT_M1;
            check($sformatf("alt%0d", k), 32'((k < seq_q.size()) ? seq_q[k] : 2'b00), 32'(want));
        end
        persist = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            tick();
            drive_random();
            sample();
        end

`ifdef WB_ARB_TIMEOUT_EN
        // Slave never acks m0; grant passes to pending m1 after the timeout
        tick();
        clear_masters();
        s_ack = 1'b0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            @(negedge clk);
            check($sformatf("to_gnt%0d", k), 32'(o_gnt), 32'h1);
            check($sformatf("to_stb%0d", k), 32'(s_if.stb), 32'(k < 16));
            check($sformatf("to_err%0d", k), 32'(m0_err), 32'd0);
        end
        tick();
        @(negedge clk);
        check("to_err_pulse", 32'(m0_err), 32'h1);
        check("to_gnt_next",  32'(o_gnt),  32'h2);
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        @(negedge clk);
        check("to_err_end", 32'(m0_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
